conway_serial_sequencer: RTL and testbench
==========================================

Name: conway_serial_sequencer

Overview:
- Host-side controller that runs one complete job on the serial 8x8 Game of Life core.
- Job steps: accept a parallel initial grid and a generation count; serially load the grid (core mode 00); step the core N times (mode 01); drain the result serially (mode 10); return the final grid in parallel with a done pulse.
- Sits between a host or register block and the core's data_in/mode/data_out pins.
- Idles the core in mode 11 (stop) whenever no job is active.

Parameters:
- DATA_SIZE, 64, grid bits (row-major: bit r*8+c).
- GEN_WIDTH, 16, width of generation count.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  job request; sampled only in IDLE.
- abort  input  1  cancel active job.
- init_grid  input  DATA_SIZE  initial pattern; latched on start acceptance.
- gen_count  input  GEN_WIDTH  generations to run; latched on start acceptance.
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle pulse; result valid.
- start_err  output  1  one-cycle pulse; start rejected.
- result  output  DATA_SIZE  final grid; holds until the next done.
- gen_remaining  output  GEN_WIDTH  generations left during RUN, else 0.
- game_mode  output  2  drives core mode.
- game_data_in  output  1  drives core data_in.
- game_data_out  input  1  from core data_out.

Behaviour:
- All outputs registered.
- Reset (reset==0 at a clk edge): state IDLE; game_mode=11, game_data_in=0, busy=0, done=0, start_err=0, result=0, gen_remaining=0. Reset mid-job drops the job silently; no done.
- States: IDLE -> LOAD -> RUN -> OUT -> IDLE.
- Acceptance: start=1 in IDLE, abort=0 and gen_count!=0 -> latch init_grid and gen_count; go to LOAD.
  - If gen_count==0: stay IDLE; start_err=1 for one cycle.
  - start while busy is ignored (no error).
- Timing (accept edge at cycle t; cycles below are output cycles):
  - LOAD, cycles t+1..t+65 (DATA_SIZE+1): game_mode=00; game_data_in = init_grid[DATA_SIZE-1] first, descending to bit 0 in cycle t+64. Cycle t+65 drives a pad bit of 0. The pad cycle is what lets the core memory capture the fully shifted pattern; it is mandatory.
  - RUN, cycles t+66..t+65+N: game_mode=01; game_data_in=0. gen_remaining=N in the first RUN cycle, decrementing each cycle, last RUN cycle shows 1.
  - OUT, cycles t+66+N..t+129+N (DATA_SIZE cycles): game_mode=10; game_data_in=0. game_data_out is sampled each cycle; the sample from OUT cycle k (0-based) is written to result[DATA_SIZE-1-k] via an internal shift register.
  - Done, cycle t+130+N: state IDLE, game_mode=11, busy=0, done=1, result updated to the full captured grid. result never shows partial captures.
- busy=1 exactly over cycles t+1..t+129+N.
- A start in the done cycle is accepted (state is IDLE); the next LOAD begins the following cycle.
- Abort:
  - In LOAD/RUN/OUT: next cycle IDLE, game_mode=11, busy=0, no done, result unchanged.
  - In IDLE: no effect, and it blocks a same-cycle start (no error pulse).
- Counters:
  - LOAD/OUT bit counter is 7 bits for DATA_SIZE=64 (sized $clog2(DATA_SIZE+1)).
  - Generation counter is GEN_WIDTH bits; the maximum count (all ones) runs in full, with no wrap.
- game_mode is never 00/01/10 outside its state. LOAD->RUN and RUN->OUT switch with no intervening 11 cycle.

Test Plan:
- Blinker, 1 generation: init_grid=64'h0000_0000_1C00_0000, gen_count=1, start at t (bench drives a real core) -> game_mode 00 for 65 cycles, 01 for 1, 10 for 64; done at t+131; result=64'h0000_0008_0808_0000.
- Blinker, 2 generations: same grid, gen_count=2 -> done at t+132; result=64'h0000_0000_1C00_0000; gen_remaining reads 2 then 1 during RUN.
- Zero generations: gen_count=0, start=1 -> start_err pulses one cycle; busy stays 0; game_mode stays 11; result unchanged.
- Busy and back-to-back: start re-asserted during RUN -> ignored. start held through the done cycle -> second job's LOAD begins at done+1, game_data_in = new init_grid MSB.
- Abort: gen_count=100, abort in the 10th RUN cycle -> next cycle game_mode=11, busy=0; no done; result keeps the previous value.
- Reset mid-LOAD: reset=0 for one edge at LOAD bit 30 -> all outputs at reset values the next cycle; a fresh start then completes a correct blinker job.

Source files
------------

// File: rtl/conway_serial_sequencer.sv
// Host-side job controller for the serial 8x8 Game of Life core: serial load, N steps,
// serial drain, then a parallel result with a done pulse.
module conway_serial_sequencer #(
  parameter int DATA_SIZE = 64,
  parameter int GEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DATA_SIZE-1:0] init_grid,
  input  logic [GEN_WIDTH-1:0] gen_count,
  output logic                 busy,
  output logic                 done,
  output logic                 start_err,
  output logic [DATA_SIZE-1:0] result,
  output logic [GEN_WIDTH-1:0] gen_remaining,
  output logic [1:0]           game_mode,
  output logic                 game_data_in,
  input  logic                 game_data_out
);

  localparam int CNT_W = $clog2(DATA_SIZE + 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(DATA_SIZE);
  localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(DATA_SIZE - 1);

  localparam logic [1:0] MODE_LOAD = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_OUT  = 2'b10;
  localparam logic [1:0] MODE_STOP = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [GEN_WIDTH-1:0] gen_lat, gen_lat_nxt;
  logic [GEN_WIDTH-1:0] gen_rem_nxt;
  logic [DATA_SIZE-1:0] load_sh, load_nxt;
  logic [DATA_SIZE-1:0] cap_sh, cap_nxt;
  logic [DATA_SIZE-1:0] result_nxt;
  logic [1:0]           mode_nxt;
  logic                 din_nxt, done_nxt, err_nxt, busy_nxt;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    gen_lat_nxt = gen_lat;
    gen_rem_nxt = gen_remaining;
    load_nxt    = load_sh;
    cap_nxt     = cap_sh;
    result_nxt  = result;
    din_nxt     = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (gen_count == '0) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt   = LOAD;
            load_nxt    = {init_grid[DATA_SIZE-2:0], 1'b0};
            din_nxt     = init_grid[DATA_SIZE-1];
            cnt_nxt     = '0;
            gen_lat_nxt = gen_count;
          end
        end
      end
      LOAD: begin
        // The trailing cycle drives the zero that has been shifted into load_sh: the pad bit.
        if (cnt == LOAD_LAST) begin
          state_nxt   = RUN;
          gen_rem_nxt = gen_lat;
        end else begin
          din_nxt  = load_sh[DATA_SIZE-1];
          load_nxt = {load_sh[DATA_SIZE-2:0], 1'b0};
          cnt_nxt  = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (gen_remaining == GEN_WIDTH'(1)) begin
          state_nxt   = OUT;
          gen_rem_nxt = '0;
          cnt_nxt     = '0;
        end else begin
          gen_rem_nxt = gen_remaining - GEN_WIDTH'(1);
        end
      end
      OUT: begin
        cap_nxt = {cap_sh[DATA_SIZE-2:0], game_data_out};
        if (cnt == OUT_LAST) begin
          state_nxt  = IDLE;
          result_nxt = cap_nxt;
          done_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort wins over every in-flight transition, including the final capture.
    if (abort && state != IDLE) begin
      state_nxt   = IDLE;
      gen_rem_nxt = '0;
      din_nxt     = 1'b0;
      done_nxt    = 1'b0;
      result_nxt  = result;
    end

    mode_nxt = MODE_STOP;
    case (state_nxt)
      LOAD:    mode_nxt = MODE_LOAD;
      RUN:     mode_nxt = MODE_RUN;
      OUT:     mode_nxt = MODE_OUT;
      default: mode_nxt = MODE_STOP;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      game_mode     <= MODE_STOP;
      game_data_in  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      start_err     <= 1'b0;
      result        <= '0;
      gen_remaining <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      game_mode     <= mode_nxt;
      game_data_in  <= din_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      start_err     <= err_nxt;
      result        <= result_nxt;
      gen_remaining <= gen_rem_nxt;
    end
  end

  always_ff @(posedge clk) begin
    load_sh <= load_nxt;
    cap_sh  <= cap_nxt;
    gen_lat <= gen_lat_nxt;
  end

endmodule

// File: tb/tb_conway_serial_sequencer.sv
// Bench for conway_serial_sequencer: behavioural serial Life core plus directed and random jobs
// checked against a generation-by-generation reference.
module tb_conway_serial_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [63:0] init_grid;
  logic [15:0] gen_count;
  logic        busy, done, start_err;
  logic [63:0] result;
  logic [15:0] gen_remaining;
  logic [1:0]  game_mode;
  logic        game_data_in, game_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conway_serial_sequencer #(.DATA_SIZE(64), .GEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .init_grid(init_grid), .gen_count(gen_count),
    .busy(busy), .done(done), .start_err(start_err), .result(result),
    .gen_remaining(gen_remaining), .game_mode(game_mode),
    .game_data_in(game_data_in), .game_data_out(game_data_out)
  );

  // One Life generation on an 8x8 grid with dead cells beyond the border.
  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] nx;
    int nb, rr, cc;
    nx = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        nb = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
              if (g[rr*8+cc]) nb++;
          end
        end
        nx[r*8+c] = (nb == 3) || (nb == 2 && g[r*8+c]);
      end
    end
    return nx;
  endfunction

  function automatic logic [63:0] life_n(input logic [63:0] g, input int n);
    logic [63:0] x;
    x = g;
    for (int i = 0; i < n; i++) x = life(x);
    return x;
  endfunction

  // Serial core: shift register feeds memory one edge late, so the pad edge commits the grid.
  logic [63:0] core_sh  = '0;
  logic [63:0] core_mem = '0;
  assign game_data_out = core_mem[63];
  always @(posedge clk) begin
    case (game_mode)
      2'b00: begin
        core_sh  <= {core_sh[62:0], game_data_in};
        core_mem <= core_sh;
      end
      2'b01: core_mem <= life(core_mem);
      2'b10: core_mem <= {core_mem[62:0], core_mem[63]};
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {busy, mode, data_in, done, start_err, gen_remaining} expected in job-relative cycle cyc.
  function automatic logic [21:0] exp_at(input int cyc, input logic [63:0] g, input int n);
    if (cyc <= 65)          return {1'b1, 2'b00, (cyc <= 64) ? g[64-cyc] : 1'b0, 1'b0, 1'b0, 16'd0};
    else if (cyc <= 65 + n) return {1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 16'(n - (cyc - 66))};
    else if (cyc <= 129 + n) return {1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 16'd0};
    else if (cyc == 130 + n) return {1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 16'd0};
    else                    return {1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 16'd0};
  endfunction

  function automatic logic [21:0] observed();
    return {busy, game_mode, game_data_in, done, start_err, gen_remaining};
  endfunction

  // Caller has driven start/init_grid/gen_count at the current negedge; the next edge accepts.
  task automatic watch(input string tag, input logic [63:0] g, input int n,
                       input bit poke, input bit chain, input logic [63:0] g2, input int n2);
    int bad;
    bad = 0;
    for (int cyc = 1; cyc <= 131 + n; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (observed() !== exp_at(cyc, g, n)) bad++;
      if (poke && cyc == 67) begin
        start = 1'b1; init_grid = ~g; gen_count = 16'd3;
      end
      if (poke && cyc == 69) start = 1'b0;
      if (cyc == 130 + n) begin
        check({tag, "_result"}, result, life_n(g, n));
        if (chain) begin
          start = 1'b1; init_grid = g2; gen_count = 16'(n2);
          break;
        end
      end
    end
    check({tag, "_seq_bad_cycles"}, 64'(bad), 64'd0);
  endtask

  task automatic check_idle(input string tag, input logic [63:0] res);
    check({tag, "_ctl"}, 64'(observed()), 64'({1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 16'd0}));
    check({tag, "_result"}, result, res);
  endtask

  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;

  initial begin
    logic [63:0] prev, g;
    int n, bad;
    reset = 1'b0; start = 1'b0; abort = 1'b0; init_grid = '0; gen_count = '0;
    repeat (3) @(negedge clk);
    check_idle("reset", 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Blinker, one and two generations
    start = 1'b1; init_grid = BLINK_H; gen_count = 16'd1;
    watch("blink1", BLINK_H, 1, 1'b0, 1'b0, '0, 0);
    check("blink1_const", result, BLINK_V);
    start = 1'b1; init_grid = BLINK_H; gen_count = 16'd2;
    watch("blink2", BLINK_H, 2, 1'b0, 1'b0, '0, 0);
    check("blink2_const", result, BLINK_H);

    // Zero generations: error pulse, no job
    start = 1'b1; init_grid = 64'hFFFF; gen_count = 16'd0;
    @(negedge clk);
    start = 1'b0;
    check("zero_err", 64'(observed()), 64'({1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 16'd0}));
    @(negedge clk);
    check_idle("zero_after", BLINK_H);

    // Abort in IDLE blocks a same-cycle start
    start = 1'b1; abort = 1'b1; gen_count = 16'd5;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_idle("abort_idle", BLINK_H);

    // Start ignored during RUN, then back-to-back via start held in the done cycle
    g = {$urandom, $urandom};
    start = 1'b1; init_grid = g; gen_count = 16'd4;
    watch("poke", g, 4, 1'b1, 1'b1, BLINK_H, 1);
    watch("chain", BLINK_H, 1, 1'b0, 1'b0, '0, 0);

    // Abort in the 10th RUN cycle
    prev = result;
    start = 1'b1; init_grid = {$urandom, $urandom}; gen_count = 16'd100;
    bad = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == 75) abort = 1'b1;
      if (cyc == 76) begin
        abort = 1'b0;
        check_idle("abort_run", prev);
      end
      if (cyc > 76 && (done || busy || game_mode != 2'b11)) bad++;
    end
    check("abort_quiet", 64'(bad), 64'd0);

    // Reset during LOAD, then a clean job
    start = 1'b1; init_grid = BLINK_H; gen_count = 16'd7;
    for (int cyc = 1; cyc <= 31; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_idle("reset_load", 64'd0);
    start = 1'b1; init_grid = BLINK_H; gen_count = 16'd1;
    watch("after_reset", BLINK_H, 1, 1'b0, 1'b0, '0, 0);
    check("after_reset_const", result, BLINK_V);

    // Random jobs
    for (int j = 0; j < 6; j++) begin
      g = {$urandom, $urandom};
      n = int'($urandom_range(1, 20));
      start = 1'b1; init_grid = g; gen_count = 16'(n);
      watch("rand", g, n, 1'b0, 1'b0, '0, 0);
    end

    // Maximum generation count runs in full
    g = {$urandom, $urandom};
    start = 1'b1; init_grid = g; gen_count = 16'hFFFF;
    watch("max_gen", g, 65535, 1'b0, 1'b0, '0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
